button_bank: RTL and testbench

Multi-channel button front end for the game controller inputs. It synchronises, polarity-normalises and debounces NUM_BTNS raw mechanical inputs against a shared 1 ms tick. Per channel it produces a clean level plus single-cycle pressed, released, long-press and auto-repeat strobes. It sits between the board pins and the game FSM and replaces per-button debounce instances.

---
 rtl/button_bank.sv | 167 ++++++++++++++++
 tb/tb_button_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// button_bank: multi-channel button front end.
// Synchronise, debounce, edge detect and long/repeat hold per channel.
module button_bank #(
  parameter int NUM_BTNS    = 4,
  parameter int CLK_FREQ    = 25_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_pressed,
  output logic [NUM_BTNS-1:0] btn_released,
  output logic [NUM_BTNS-1:0] btn_long,
  output logic [NUM_BTNS-1:0] btn_repeat,
  output logic                any_pressed
);

  localparam int TICK_DIV = CLK_FREQ / 1000;
  localparam int TW       = $clog2(TICK_DIV);
  localparam int DB_W     = $clog2(DEBOUNCE_MS + 1);
  localparam int HMAX     = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int HW       = $clog2(HMAX + 1);
  localparam logic [NUM_BTNS-1:0] IDLE_RAW = {NUM_BTNS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_e;

  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic [NUM_BTNS-1:0] sync1_q, sync1_d;
  logic [NUM_BTNS-1:0] sync2_q, sync2_d;
  logic [NUM_BTNS-1:0] sync_n;
  logic [NUM_BTNS-1:0] level_q, level_d;
  logic [NUM_BTNS-1:0] prev_q, prev_d;
  logic [DB_W-1:0]     db_cnt_q [NUM_BTNS];
  logic [DB_W-1:0]     db_cnt_d [NUM_BTNS];
  state_e              state_q [NUM_BTNS];
  state_e              state_d [NUM_BTNS];
  logic [HW-1:0]       hold_cnt_q [NUM_BTNS];
  logic [HW-1:0]       hold_cnt_d [NUM_BTNS];
  logic [NUM_BTNS-1:0] pressed_q, pressed_d;
  logic [NUM_BTNS-1:0] released_q, released_d;
  logic [NUM_BTNS-1:0] long_q, long_d;
  logic [NUM_BTNS-1:0] repeat_q, repeat_d;
  logic                any_q, any_d;
  logic                match;
  logic                last_db;

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    sync1_d    = btn_in;
    sync2_d    = sync1_q;
    sync_n     = sync2_q ^ IDLE_RAW;
    prev_d     = level_q;
    pressed_d  = level_q & ~prev_q;
    released_d = ~level_q & prev_q;
    any_d      = |pressed_d;
    level_d    = level_q;
    long_d     = '0;
    repeat_d   = '0;
    match      = 1'b0;
    last_db    = 1'b0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      db_cnt_d[i]   = db_cnt_q[i];
      state_d[i]    = state_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      match   = (sync_n[i] == level_q[i]);
      last_db = (db_cnt_q[i] == DB_W'(DEBOUNCE_MS - 1));
      unique case (1'b1)
        match: db_cnt_d[i] = '0;
        (!match && tick && last_db): begin
          level_d[i]  = sync_n[i];
          db_cnt_d[i] = '0;
        end
        (!match && tick && !last_db):
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        default: ;
      endcase
      // A released level wins over any tick in the same cycle.
      if (!level_q[i]) begin
        state_d[i]    = IDLE;
        hold_cnt_d[i] = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            state_d[i]    = HOLD;
            hold_cnt_d[i] = '0;
          end
          HOLD: begin
            if (tick && hold_cnt_q[i] != HW'(LONG_MS)) begin
              if (hold_cnt_q[i] == HW'(LONG_MS - 1)) begin
                long_d[i]     = 1'b1;
                hold_cnt_d[i] = (REPEAT_MS == 0) ? HW'(LONG_MS) : '0;
                state_d[i]    = (REPEAT_MS == 0) ? HOLD : REPEAT;
              end else begin
                hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (tick) begin
              if (hold_cnt_q[i] == HW'(REPEAT_MS - 1)) begin
                repeat_d[i]   = 1'b1;
                hold_cnt_d[i] = '0;
              end else begin
                hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
              end
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      sync1_q    <= IDLE_RAW;
      sync2_q    <= IDLE_RAW;
      level_q    <= '0;
      prev_q     <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      long_q     <= '0;
      repeat_q   <= '0;
      any_q      <= 1'b0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        db_cnt_q[i]   <= '0;
        state_q[i]    <= IDLE;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      prev_q     <= prev_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      any_q      <= any_d;
      for (int i = 0; i < NUM_BTNS; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        state_q[i]    <= state_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign btn_level    = level_q;
  assign btn_pressed  = pressed_q;
  assign btn_released = released_q;
  assign btn_long     = long_q;
  assign btn_repeat   = repeat_q;
  assign any_pressed  = any_q;

endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: directed bench for button_bank.
// Tick = 4 cycles, debounce 3, long 5, repeat 2.
module tb_button_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_in, btn_in_l;
  logic [3:0] btn_level, btn_pressed, btn_released;
  logic [3:0] btn_long, btn_repeat;
  logic       any_pressed;
  logic [3:0] btn_level_l, btn_pressed_l, btn_released_l;
  logic [3:0] btn_long_l, btn_repeat_l;
  logic       any_pressed_l;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic clr = 1'b0;

  int n_press [4], n_rel [4], n_long [4], n_rep [4];
  int t_press [4], t_rel [4], t_long [4], t_rep [4];
  int t_rise [4], t_fall [4], rep_bad [4];
  int saw_1001, any_bad, al_strobe, al_press, gap;
  logic [3:0] lvl_prev = '0;
  int t0, d0;

  button_bank #(
    .NUM_BTNS(4), .CLK_FREQ(4000), .DEBOUNCE_MS(3),
    .LONG_MS(5), .REPEAT_MS(2), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_pressed(btn_pressed),
    .btn_released(btn_released), .btn_long(btn_long),
    .btn_repeat(btn_repeat), .any_pressed(any_pressed)
  );

  button_bank #(
    .NUM_BTNS(4), .CLK_FREQ(4000), .DEBOUNCE_MS(3),
    .LONG_MS(5), .REPEAT_MS(2), .ACTIVE_LOW(1'b1)
  ) u_dut_l (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in_l),
    .btn_level(btn_level_l), .btn_pressed(btn_pressed_l),
    .btn_released(btn_released_l), .btn_long(btn_long_l),
    .btn_repeat(btn_repeat_l), .any_pressed(any_pressed_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_rep[i] = 0;
        t_press[i] = 0; t_rel[i] = 0; t_long[i] = 0; t_rep[i] = 0;
        t_rise[i] = 0; t_fall[i] = 0; rep_bad[i] = 0;
      end
      saw_1001 = 0;
      any_bad = 0;
    end else if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (btn_level[i] && !lvl_prev[i]) t_rise[i] = cyc;
        if (!btn_level[i] && lvl_prev[i]) t_fall[i] = cyc;
        if (btn_pressed[i]) begin n_press[i]++; t_press[i] = cyc; end
        if (btn_released[i]) begin n_rel[i]++; t_rel[i] = cyc; end
        if (btn_long[i]) begin n_long[i]++; t_long[i] = cyc; end
        if (btn_repeat[i]) begin
          gap = cyc - ((n_rep[i] == 0) ? t_long[i] : t_rep[i]);
          if (gap != 8) rep_bad[i]++;
          n_rep[i]++;
          t_rep[i] = cyc;
        end
      end
      if (btn_pressed == 4'b1001 && any_pressed) saw_1001++;
      if (any_pressed != |btn_pressed) any_bad++;
      if ((btn_pressed_l | btn_released_l | btn_long_l | btn_repeat_l) != 0)
        al_strobe++;
      if (btn_pressed_l[0]) al_press++;
    end
    lvl_prev = btn_level;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic wait_level(input int ch, input logic v, input string tag);
    int g = 0;
    while (btn_level[ch] !== v && g < 60) begin step(1); g++; end
    chk(tag, int'(btn_level[ch] === v), 1);
  endtask

  function automatic int outs();
    return int'({btn_level, btn_pressed, btn_released,
                 btn_long, btn_repeat, any_pressed});
  endfunction

  function automatic int outs_l();
    return int'({btn_level_l, btn_pressed_l, btn_released_l,
                 btn_long_l, btn_repeat_l, any_pressed_l});
  endfunction

  initial begin
    int g;
    al_strobe = 0;
    al_press = 0;
    btn_in = 4'h0;
    btn_in_l = 4'hF;
    rst_n = 1'b0;
    do_clr();
    step(2);
    chk("rst_outs", outs(), 0);
    chk("rst_outs_l", outs_l(), 0);
    rst_n = 1'b1;
    step(1);
    chk("rel_first", outs(), 0);
    step(2);

    do_clr();
    t0 = cyc;
    btn_in[0] = 1'b1;
    wait_level(0, 1'b1, "c0_rise");
    chk("c0_lat", int'(t_rise[0] - t0 >= 11 && t_rise[0] - t0 <= 14), 1);
    step(48);
    btn_in[0] = 1'b0;
    wait_level(0, 1'b0, "c0_fall");
    step(5);
    chk("c0_npress", n_press[0], 1);
    chk("c0_press_dly", t_press[0] - t_rise[0], 1);
    chk("c0_nrel", n_rel[0], 1);
    chk("c0_rel_dly", t_rel[0] - t_fall[0], 1);
    chk("c0_nlong", n_long[0], 1);
    chk("c0_quiet", n_press[1] + n_press[2] + n_press[3] +
        n_rel[1] + n_rel[2] + n_rel[3] + n_long[1] + n_long[2] +
        n_long[3] + n_rep[1] + n_rep[2] + n_rep[3], 0);

    do_clr();
    for (int k = 0; k < 8; k++) begin
      btn_in[1] = (k % 2 == 0);
      step(5);
    end
    chk("b1_nopress", n_press[1] + n_rel[1], 0);
    chk("b1_lvl", int'(btn_level[1]), 0);
    btn_in[1] = 1'b1;
    wait_level(1, 1'b1, "b1_rise");
    step(3);
    chk("b1_npress", n_press[1], 1);
    btn_in[1] = 1'b0;
    wait_level(1, 1'b0, "b1_fall");
    step(3);

    do_clr();
    btn_in[2] = 1'b1;
    wait_level(2, 1'b1, "l2_rise");
    g = 0;
    while (n_rep[2] < 2 && g < 100) begin step(1); g++; end
    chk("l2_rep2_seen", n_rep[2], 2);
    btn_in[2] = 1'b0;
    wait_level(2, 1'b0, "l2_fall");
    step(20);
    chk("l2_nlong", n_long[2], 1);
    chk("l2_long_dly", t_long[2] - t_rise[2], 20);
    chk("l2_nrep", n_rep[2], 3);
    chk("l2_rep_gap", rep_bad[2], 0);
    chk("l2_fall_mid", t_fall[2] - t_rep[2], 4);
    chk("l2_nrel", n_rel[2], 1);

    do_clr();
    btn_in = 4'b1001;
    wait_level(0, 1'b1, "s_rise");
    step(3);
    chk("s_1001", saw_1001, 1);
    chk("s_any_bad", any_bad, 0);
    chk("s_press_n", n_press[0] * 10 + n_press[3], 11);
    chk("s_same_cyc", t_press[0] - t_press[3], 0);
    btn_in = 4'b0000;
    wait_level(0, 1'b0, "s_fall");
    step(5);

    chk("al_quiet", al_strobe, 0);
    chk("al_lvl0", int'(btn_level_l), 0);
    btn_in_l[0] = 1'b0;
    g = 0;
    while (!btn_level_l[0] && g < 60) begin step(1); g++; end
    step(3);
    chk("al_lvl", int'(btn_level_l), 1);
    chk("al_press", al_press, 1);
    btn_in_l[0] = 1'b1;
    step(20);

    do_clr();
    btn_in[2] = 1'b1;
    wait_level(2, 1'b1, "r2_rise");
    g = 0;
    while (n_rep[2] < 1 && g < 100) begin step(1); g++; end
    chk("r2_in_rep", n_rep[2], 1);
    rst_n = 1'b0;
    #1;
    chk("r2_async", outs(), 0);
    do_clr();
    step(2);
    rst_n = 1'b1;
    d0 = cyc;
    step(1);
    chk("r2_first", outs(), 0);
    step(8);
    chk("r2_no_early", int'(btn_level[2]), 0);
    wait_level(2, 1'b1, "r2_rise2");
    step(2);
    chk("r2_rise_dly", t_rise[2] - d0, 12);
    chk("r2_press_dly", t_press[2] - d0, 13);
    btn_in[2] = 1'b0;
    wait_level(2, 1'b0, "r2_fall");
    step(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
